// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional feature macro: NSA_SIGNED_OVF_EN (adds signed-overflow output).
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        NSA_IDLE,
        NSA_RUN,
        NSA_DONE
    } nsa_state_t;

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// 4-bit ripple-carry adder slice built from single-bit full-adder cells.
// Purely combinational; the sequencer around it owns all state.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_add_slice
    import nsa_pkg::*;
(
    output logic                c_out,
    output logic [NIBBLE_W-1:0] s,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in
);
    logic [NIBBLE_W:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        full_adder_cell u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign c_out = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit slice: operands are latched on accept and
// summed one nibble per cycle, LSB first, with the carry held in a register.
// Optional feature macro: NSA_SIGNED_OVF_EN (adds the ovf output).
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef NSA_SIGNED_OVF_EN
    output logic [WIDTH:0]   sum,
    output logic             ovf
`else
    output logic [WIDTH:0]   sum
`endif
);
    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
        $fatal(1, "nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    nsa_state_t                       state;
    logic [N-1:0][NIBBLE_W-1:0]       a_r;
    logic [N-1:0][NIBBLE_W-1:0]       b_r;
    logic [N-1:0][NIBBLE_W-1:0]       sum_lo;
    logic                             sum_hi;
    logic                             carry;
    logic [IDX_W-1:0]                 idx;

    logic [NIBBLE_W-1:0]              sl_s;
    logic                             sl_co;

    // The single shared slice always works on the nibble selected by idx.
    nibble_add_slice u_slice (
        .c_out (sl_co),
        .s     (sl_s),
        .a     (a_r[idx]),
        .b     (b_r[idx]),
        .c_in  (carry)
    );

    assign sum = {sum_hi, sum_lo};

    // Sequencer: accept operands, walk the nibbles, then hold the result
    // until the consumer takes it. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= NSA_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum_lo    <= '0;
            sum_hi    <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
`ifdef NSA_SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                NSA_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry    <= c_in;
                        // Clear so partially built sums never expose old data.
                        sum_lo   <= '0;
                        sum_hi   <= 1'b0;
                        idx      <= '0;
                        in_ready <= 1'b0;
`ifdef NSA_SIGNED_OVF_EN
                        ovf      <= 1'b0;
`endif
                        state    <= NSA_RUN;
                    end
                end
                NSA_RUN: begin
                    sum_lo[idx] <= sl_s;
                    carry       <= sl_co;
                    if (idx == LAST_IDX) begin
                        sum_hi    <= sl_co;
                        idx       <= '0;
                        out_valid <= 1'b1;
`ifdef NSA_SIGNED_OVF_EN
                        // Same-sign operands whose result sign differs.
                        ovf <= (a_r[N-1][NIBBLE_W-1] == b_r[N-1][NIBBLE_W-1]) &&
                               (sl_s[NIBBLE_W-1] != a_r[N-1][NIBBLE_W-1]);
`endif
                        state     <= NSA_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                NSA_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= NSA_IDLE;
                    end
                end
                default: begin
                    state <= NSA_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): the driver pushes the
// hand-computed result at each accept, a monitor pops and compares on every
// output handshake. Build with NSA_SIGNED_OVF_EN to also cover ovf.
module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;
`ifdef NSA_SIGNED_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W:0] sum;
        logic       ovf;
        int         acc_cyc;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_hs = -1;
    logic prev_ov = 1'b0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef NSA_SIGNED_OVF_EN
        .sum       (sum),
        .ovf       (ovf)
`else
        .sum       (sum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, data on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: out_valid with empty scoreboard, sum=0x%0h", sum);
                end else begin
                    chk({q[0].name, "_latency"}, (W+1)'(cyc - q[0].acc_cyc), (W+1)'(N));
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_sum"}, sum, e.sum);
`ifdef NSA_SIGNED_OVF_EN
                chk({e.name, "_ovf"}, (W+1)'(ovf), (W+1)'(e.ovf));
`endif
                last_hs = cyc + 1;
            end
        end
        prev_ov = rst ? 1'b0 : out_valid;
    end

    // Present one operation, wait for the accept edge, and queue its expectation.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic [W:0] es, input logic eo, input string nm, input bit track);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL %s_accept: in_ready stuck at 0 expected 1", nm);
            return;
        end
        a = ta; b = tb_; c_in = tc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (cyc <= last_hs) begin
            errors++;
            $display("FAIL %s_accept_order: accept cycle %0d expected > %0d", nm, cyc, last_hs);
        end
        if (track) q.push_back('{sum: es, ovf: eo, acc_cyc: cyc, name: nm});
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: %0d results outstanding expected 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", (W+1)'(in_ready), (W+1)'(1));
        chk("reset_out_valid", (W+1)'(out_valid), '0);
        chk("reset_sum", sum, '0);
`ifdef NSA_SIGNED_OVF_EN
        chk("reset_ovf", (W+1)'(ovf), '0);
`endif
        rst = 1'b0;

        do_op(16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0, "zero", 1); drain("zero");
        do_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, "ripple", 1); drain("ripple");

        do_op(16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b0, "latched", 1);
        @(negedge clk);
        a = 16'hDEAD; b = 16'hDEAD; c_in = 1'b0;
        drain("latched");

        do_op(16'hA5A5, 16'h5A5A, 1'b0, 17'h0FFFF, 1'b0, "alt", 1); drain("alt");
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 17'h10000, 1'b0, "alt_cin", 1); drain("alt_cin");

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0, "stall", 1);
        begin
            int t = 0;
            while (!out_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_sum", sum, 17'h1FFFF);
            chk("stall_hold_valid", (W+1)'(out_valid), (W+1)'(1));
            chk("stall_in_ready", (W+1)'(in_ready), '0);
        end
        out_ready = 1'b1;
        drain("stall");
        do_op(16'h0100, 16'h0F00, 1'b0, 17'h01000, 1'b0, "after_stall", 1); drain("after_stall");

        // Reset while RUN is on nibble 2: result must be discarded.
        do_op(16'h1234, 16'h1111, 1'b0, 17'h02345, 1'b0, "aborted", 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", (W+1)'(out_valid), '0);
        chk("midrst_sum", sum, '0);
        chk("midrst_in_ready", (W+1)'(in_ready), (W+1)'(1));
        rst = 1'b0;
        do_op(16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b0, "post_rst", 1); drain("post_rst");

`ifdef NSA_SIGNED_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, "ovf_pos", 1); drain("ovf_pos");
        do_op(16'h8000, 16'hFFFF, 1'b0, 17'h17FFF, 1'b1, "ovf_neg", 1); drain("ovf_neg");
        do_op(16'h0005, 16'hFFFE, 1'b0, 17'h10003, 1'b0, "ovf_none", 1); drain("ovf_none");
`endif

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
